alu_ctrl_mdu: RTL

Parametrised successor of the EX-stage ALU control decoder. Decodes aluOp/ff into the 4-bit ALU operation code and also owns the HI/LO registers. Sequences multi-cycle MULT/MULTU/DIV/DIVU with a pipeline stall output. Sits in the EX stage beside the ALU; stall feeds the hazard unit, mdu_result feeds the EX result mux.

---
 rtl/alu_ctrl_mdu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decoder with HI/LO registers and iterative MDU.
// Ports: clk, rst_n (sync, active-low), valid, ff, aluOp, rs_val, rt_val
//   -> operation, stall, mdu_result, busy; div0 when MDU_DIV0_FLAG_EN.
module alu_ctrl_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [5:0]       ff,
  input  logic [5:0]       aluOp,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       operation,
  output logic             stall,
  output logic [WIDTH-1:0] mdu_result,
  output logic             busy
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic r_type, md_op, mf_op, mt_op;
  logic is_md, is_mf, is_mt;

  assign r_type = (aluOp == 6'b000010);
  assign md_op  = r_type && (ff[5:2] == 4'b0110);
  assign mf_op  = r_type &&
                  (ff == 6'b010000 || ff == 6'b010010);
  assign mt_op  = r_type &&
                  (ff == 6'b010001 || ff == 6'b010011);
  assign is_md  = valid && md_op;
  assign is_mf  = valid && mf_op;
  assign is_mt  = valid && mt_op;

  // ALU operation decode
  always_comb begin
    operation = 4'b1111;
    if (aluOp[5]) begin
      unique case (aluOp[4:2])
        3'b000,
        3'b001:  operation = 4'b0010;
        3'b010:  operation = 4'b0111;
        3'b011:  operation = 4'b1000;
        3'b100:  operation = 4'b0000;
        3'b101:  operation = 4'b0001;
        3'b110:  operation = 4'b0011;
        default: operation = 4'b1101;
      endcase
    end else if (aluOp == 6'b000000) begin
      operation = 4'b0010;
    end else if (aluOp == 6'b000001) begin
      operation = 4'b0110;
    end else if (r_type) begin
      case (ff)
        6'b100000,
        6'b100001: operation = 4'b0010;
        6'b100010,
        6'b100011: operation = 4'b0110;
        6'b100100: operation = 4'b0000;
        6'b100101: operation = 4'b0001;
        6'b100110: operation = 4'b0011;
        6'b100111: operation = 4'b1100;
        6'b101010: operation = 4'b0111;
        6'b101011: operation = 4'b1000;
        6'b000000: operation = 4'b1001;
        6'b000010: operation = 4'b1010;
        6'b000011: operation = 4'b1011;
        6'b010000,
        6'b010010: operation = 4'b1110;
        default:   operation = 4'b1111;
      endcase
    end
  end

  // operand magnitudes; ff[0]=1 selects the unsigned variants
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign sgn_op = ~ff[0];
  assign a_neg  = sgn_op & rs_val[WIDTH-1];
  assign b_neg  = sgn_op & rt_val[WIDTH-1];
  assign a_abs  = a_neg ? -rs_val : rs_val;
  assign b_abs  = b_neg ? -rt_val : rt_val;

  // mul: {acc_hi,acc_lo} is the shifting product/multiplier
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} +
                   (acc_lo[0] ? {1'b0, opnd} : '0);

  // div: acc_hi is the partial remainder, acc_lo the quotient
  logic [WIDTH:0]   rem_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_sub;
  assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok  = (rem_sh >= {1'b0, opnd});
  assign div_sub = WIDTH'(rem_sh - {1'b0, opnd});

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fin_hi, fin_lo;
  logic               div_zero;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -acc_lo : acc_lo;
  assign r_fix    = neg_r ? -acc_hi : acc_hi;
  assign div_zero = (opnd == '0);

  // a zero divisor leaves the dividend in the remainder,
  // so the corrected remainder already equals raw rs_val
  assign fin_hi = is_div ? r_fix
                         : prod_fix[2*WIDTH-1:WIDTH];
  assign fin_lo = is_div ? (div_zero ? '1 : q_fix)
                         : prod_fix[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_md) begin
          stall    = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (cnt == CNT_W'(1)) state_nx = FIN;
      end
      FIN: begin
        // the issuing mul/div retires here; HI/LO
        // readers/writers must wait one more cycle
        stall    = is_mf | is_mt;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && is_md) begin
        cnt    <= CNT_W'(WIDTH);
        acc_hi <= '0;
        acc_lo <= a_abs;
        opnd   <= b_abs;
        is_div <= ff[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
      end
      if (state == IDLE && is_mt) begin
        if (ff[1]) lo <= rs_val;
        else       hi <= rs_val;
      end
      if (state == RUN) begin
        cnt <= cnt - 1'b1;
        if (is_div) begin
          acc_hi <= div_ok ? div_sub
                           : rem_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end
      if (state == FIN) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    mdu_result = '0;
    if (state == IDLE && is_mf)
      mdu_result = ff[1] ? lo : hi;
  end

`ifdef MDU_DIV0_FLAG_EN
  assign div0 = (state == FIN) && is_div && div_zero;
`endif

endmodule
